// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared types and widths for the memory-controller port arbiter.
package mem_ctrl_arbiter_pkg;

    localparam int SRAM_AW   = 10;
    localparam int EXT_AW    = 30;
    localparam int MC_PROG_W = 10;

    typedef struct packed {
        logic               we;
        logic [SRAM_AW-1:0] sramAddr;
        logic [EXT_AW-1:0]  extAddr;
    } MemRq_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ACTIVE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_ctrl_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);

    int idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!valid && req[idx[ID_W-1:0]]) begin
                valid  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// Round-robin arbiter sharing the single MC transfer port between cache controllers.
// state  | meaning
// IDLE   | nothing owned; grant when a request is pending and the MC is free
// ISSUE  | command strobe out; MC busy not yet valid, so it is ignored
// ACTIVE | waiting for MC busy to drop, then signal done to the owner
module mem_ctrl_arbiter
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          IN_rqCe,
    input  logic [NUM_REQ-1:0]          IN_rqWe,
    input  logic [NUM_REQ*SRAM_AW-1:0]  IN_rqSramAddr,
    input  logic [NUM_REQ*EXT_AW-1:0]   IN_rqExtAddr,
    output logic [NUM_REQ-1:0]          OUT_rqReady,
    output logic [NUM_REQ-1:0]          OUT_rqBusy,
    output logic [NUM_REQ-1:0]          OUT_rqDone,
    output logic [MC_PROG_W-1:0]        OUT_rqProgress,
    output logic                        OUT_MC_ce,
    output logic                        OUT_MC_we,
    output logic [SRAM_AW-1:0]          OUT_MC_sramAddr,
    output logic [EXT_AW-1:0]           OUT_MC_extAddr,
    output logic [ID_W-1:0]             OUT_MC_cacheID,
    input  logic                        IN_MC_busy,
    input  logic [MC_PROG_W-1:0]        IN_MC_progress
);

    arb_state_t         state, state_nxt;
    MemRq_t             slot [NUM_REQ];
    logic [NUM_REQ-1:0] pending, accept, grant;
    logic [ID_W-1:0]    owner, rr_ptr, pick_idx;
    logic               pick_valid, issue, finish, in_flight;

    rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req    (pending),
        .ptr    (rr_ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign in_flight      = (state != ST_IDLE);
    assign OUT_rqProgress = IN_MC_progress;
    assign accept         = IN_rqCe & OUT_rqReady;

    always_comb begin
        OUT_rqReady = '0;
        OUT_rqBusy  = '0;
        grant       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            OUT_rqReady[i] = !pending[i] && !(in_flight && owner == ID_W'(i));
            OUT_rqBusy[i]  =  pending[i] ||  (in_flight && owner == ID_W'(i));
            grant[i]       = issue && (pick_idx == ID_W'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid && !IN_MC_busy) begin
                    issue     = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (!IN_MC_busy) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Slots only matter while pending, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                slot[i] <= '{we:       IN_rqWe[i],
                             sramAddr: IN_rqSramAddr[i*SRAM_AW +: SRAM_AW],
                             extAddr:  IN_rqExtAddr[i*EXT_AW +: EXT_AW]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending         <= '0;
            owner           <= '0;
            rr_ptr          <= '0;
            OUT_rqDone      <= '0;
            OUT_MC_ce       <= 1'b0;
            OUT_MC_we       <= 1'b0;
            OUT_MC_sramAddr <= '0;
            OUT_MC_extAddr  <= '0;
            OUT_MC_cacheID  <= '0;
        end else begin
            pending   <= (pending & ~grant) | accept;
            OUT_MC_ce <= issue;
            if (issue) begin
                owner           <= pick_idx;
                OUT_MC_we       <= slot[pick_idx].we;
                OUT_MC_sramAddr <= slot[pick_idx].sramAddr;
                OUT_MC_extAddr  <= slot[pick_idx].extAddr;
                OUT_MC_cacheID  <= pick_idx;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                OUT_rqDone[i] <= finish && (owner == ID_W'(i));
            end
            if (finish) begin
                rr_ptr <= (owner == ID_W'(NUM_REQ-1)) ? '0 : owner + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Bench for mem_ctrl_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_ctrl_arbiter;

    localparam int NREQ = 2;

    logic             clk;
    logic             rst;
    logic [1:0]       rq_ce, rq_we;
    logic [19:0]      rq_sram;
    logic [59:0]      rq_ext;
    logic [1:0]       ready, busy, done;
    logic [9:0]       rq_prog, mc_prog;
    logic             mc_ce, mc_we, mc_busy, mc_cyc_busy, ext_busy;
    logic [9:0]       mc_sram;
    logic [29:0]      mc_ext;
    logic [0:0]       mc_id;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int mc_cnt, mc_lat, t0, d0;
    int done_cyc [2];
    int ce_id_q[$];
    int ce_cyc_q[$];
    bit reposted;
    logic [1:0] rnd_rdy;

    // transaction-level model state
    bit [1:0]    m_pend;
    logic        m_we   [2];
    logic [9:0]  m_sram [2];
    logic [29:0] m_ext  [2];
    bit          m_flight, m_guard;
    int          m_owner, m_ptr;
    bit          x_ce;
    logic [1:0]  x_done;
    int          x_id;
    logic        x_we;
    logic [9:0]  x_sram;
    logic [29:0] x_ext;

    assign mc_busy = mc_cyc_busy | ext_busy;

    mem_ctrl_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk             (clk),
        .rst             (rst),
        .IN_rqCe         (rq_ce),
        .IN_rqWe         (rq_we),
        .IN_rqSramAddr   (rq_sram),
        .IN_rqExtAddr    (rq_ext),
        .OUT_rqReady     (ready),
        .OUT_rqBusy      (busy),
        .OUT_rqDone      (done),
        .OUT_rqProgress  (rq_prog),
        .OUT_MC_ce       (mc_ce),
        .OUT_MC_we       (mc_we),
        .OUT_MC_sramAddr (mc_sram),
        .OUT_MC_extAddr  (mc_ext),
        .OUT_MC_cacheID  (mc_id),
        .IN_MC_busy      (mc_busy),
        .IN_MC_progress  (mc_prog)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [1:0] model_ready();
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) r[i] = !m_pend[i] && !(m_flight && m_owner == i);
        return r;
    endfunction

    function automatic int model_pick();
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (m_pend[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic int ce_cyc_at(int k);
        return (k < ce_cyc_q.size()) ? ce_cyc_q[k] : -1;
    endfunction

    function automatic int ce_id_at(int k);
        return (k < ce_id_q.size()) ? ce_id_q[k] : -1;
    endfunction

    task automatic model_clear();
        m_pend   = '0;
        m_flight = 1'b0;
        m_guard  = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        x_ce     = 1'b0;
        x_done   = '0;
    endtask

    task automatic post(input int i, input bit we, input logic [9:0] s, input logic [29:0] e);
        rq_ce[i]          = 1'b1;
        rq_we[i]          = we;
        rq_sram[i*10 +: 10] = s;
        rq_ext[i*30 +: 30]  = e;
    endtask

    // Check this cycle at the negedge, advance the model, then move to just after the next posedge.
    task automatic eval();
        logic [1:0] rdy_e, busy_e;
        bit done_nx, issue_nx;
        int w;
        @(negedge clk);
        if (!rst) begin
            model_clear();
            mc_cnt = 0;
        end else begin
            rdy_e  = model_ready();
            busy_e = '0;
            for (int i = 0; i < NREQ; i++) busy_e[i] = m_pend[i] || (m_flight && m_owner == i);
            chk_val("ready", ready, rdy_e);
            chk_val("busy", busy, busy_e);
            chk_val("done", done, x_done);
            chk_val("mc_ce", mc_ce, x_ce);
            chk_val("progress", rq_prog, mc_prog);
            chk_val("proto_ce_not_ready", rq_ce & ~rdy_e, 2'b00);
            if (x_ce && mc_ce) begin
                chk_val("mc_id", mc_id, x_id);
                chk_val("mc_we", mc_we, x_we);
                chk_val("mc_sram", mc_sram, x_sram);
                chk_val("mc_ext", mc_ext, x_ext);
            end
            if (mc_ce) begin
                ce_id_q.push_back(int'(mc_id));
                ce_cyc_q.push_back(cyc);
                mc_cnt = mc_lat;
            end
            for (int i = 0; i < NREQ; i++) if (done[i]) done_cyc[i] = cyc;

            done_nx  = m_flight && !m_guard && !mc_busy;
            issue_nx = !m_flight && (m_pend != 0) && !mc_busy;
            w        = model_pick();
            x_ce     = issue_nx;
            x_done   = '0;
            m_guard  = 1'b0;
            if (done_nx) begin
                x_done[m_owner] = 1'b1;
                m_flight        = 1'b0;
                m_ptr           = (m_owner + 1) % NREQ;
            end
            if (issue_nx) begin
                m_pend[w] = 1'b0;
                m_flight  = 1'b1;
                m_guard   = 1'b1;
                m_owner   = w;
                x_id      = w;
                x_we      = m_we[w];
                x_sram    = m_sram[w];
                x_ext     = m_ext[w];
            end
            for (int i = 0; i < NREQ; i++) begin
                if (rq_ce[i] && rdy_e[i]) begin
                    m_pend[i] = 1'b1;
                    m_we[i]   = rq_we[i];
                    m_sram[i] = rq_sram[i*10 +: 10];
                    m_ext[i]  = rq_ext[i*30 +: 30];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        rq_ce = '0;
        if (mc_cnt > 0) begin
            mc_cyc_busy = 1'b1;
            mc_cnt--;
        end else begin
            mc_cyc_busy = 1'b0;
        end
        mc_prog = 10'($urandom);
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) eval();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        run_idle(n);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; rq_ce = '0; rq_we = '0; rq_sram = '0; rq_ext = '0;
        mc_cyc_busy = 1'b0; ext_busy = 1'b0; mc_prog = '0; mc_cnt = 0; mc_lat = 4;
        done_cyc[0] = -1; done_cyc[1] = -1;
        model_clear();

        // reset with both request strobes held high
        rq_ce = 2'b11; eval();
        rq_ce = 2'b11; eval();
        rst = 1'b1;
        chk_val("rst_ready", ready, 2'b11);
        chk_val("rst_busy", busy, 2'b00);
        chk_val("rst_done", done, 2'b00);
        chk_val("rst_mc_ce", mc_ce, 1'b0);
        chk_val("rst_mc_fields", {mc_we, mc_sram, mc_ext, mc_id}, 42'd0);
        run_idle(3);

        // single fill with 8-cycle MC transfer
        ce_id_q.delete(); ce_cyc_q.delete();
        mc_lat = 8; t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) post(0, 1'b0, 10'h040, 30'h0001_2340);
            chk_val("t2_busy0", busy[0], (k >= 1 && k <= 11));
            eval();
        end
        chk_val("t2_ce_cyc", ce_cyc_at(0) - t0, 2);
        chk_val("t2_ce_id", ce_id_at(0), 0);
        chk_val("t2_done_cyc", done_cyc[0] - t0, 12);

        // contention from rrPtr=0
        do_reset(2);
        ce_id_q.delete(); ce_cyc_q.delete();
        mc_lat = 4; t0 = cyc;
        post(0, 1'($urandom), 10'($urandom), 30'($urandom));
        post(1, 1'($urandom), 10'($urandom), 30'($urandom));
        run_idle(30);
        chk_val("t3a_first", ce_id_at(0), 0);
        chk_val("t3a_second", ce_id_at(1), 1);
        chk_val("t3a_ce1_cyc", ce_cyc_at(1) - t0, 9);
        chk_val("t3a_after_done", ce_cyc_at(1), done_cyc[0] + 1);

        // contention from rrPtr=1 (last owner was req0)
        post(0, 1'($urandom), 10'($urandom), 30'($urandom));
        run_idle(12);
        ce_id_q.delete(); ce_cyc_q.delete();
        post(0, 1'($urandom), 10'($urandom), 30'($urandom));
        post(1, 1'($urandom), 10'($urandom), 30'($urandom));
        run_idle(30);
        chk_val("t3b_first", ce_id_at(0), 1);
        chk_val("t3b_second", ce_id_at(1), 0);

        // back-to-back: req1 re-posts on its done cycle while req0 waits
        ce_id_q.delete(); ce_cyc_q.delete();
        mc_lat = 3; reposted = 1'b0;
        post(1, 1'($urandom), 10'($urandom), 30'($urandom));
        for (int k = 0; k < 40; k++) begin
            if (k == 3) post(0, 1'($urandom), 10'($urandom), 30'($urandom));
            if (k > 0 && done[1] && !reposted) begin
                post(1, 1'($urandom), 10'($urandom), 30'($urandom));
                reposted = 1'b1;
            end
            eval();
        end
        chk_val("t4_count", ce_id_q.size(), 3);
        chk_val("t4_order0", ce_id_at(0), 1);
        chk_val("t4_order1", ce_id_at(1), 0);
        chk_val("t4_order2", ce_id_at(2), 1);
        chk_val("t4_req1_after_req0", ce_cyc_at(2), done_cyc[0] + 1);

        // MC busy held high while idle delays the grant
        ce_id_q.delete(); ce_cyc_q.delete();
        mc_lat = 2; t0 = cyc; ext_busy = 1'b1;
        post(0, 1'($urandom), 10'($urandom), 30'($urandom));
        for (int k = 0; k < 16; k++) begin
            if (k == 6) ext_busy = 1'b0;
            eval();
        end
        chk_val("t5_ce_cyc", ce_cyc_at(0) - t0, 7);

        // reset during ACTIVE abandons the transfer
        ce_id_q.delete(); ce_cyc_q.delete();
        mc_lat = 20;
        post(0, 1'($urandom), 10'($urandom), 30'($urandom));
        run_idle(6);
        d0 = done_cyc[0];
        do_reset(1);
        chk_val("t6_ready", ready, 2'b11);
        chk_val("t6_busy", busy, 2'b00);
        run_idle(25);
        chk_val("t6_no_done", done_cyc[0], d0);
        ce_id_q.delete(); ce_cyc_q.delete();
        mc_lat = 2; t0 = cyc;
        post(0, 1'($urandom), 10'($urandom), 30'($urandom));
        run_idle(10);
        chk_val("t6_fresh_ce", ce_cyc_at(0) - t0, 2);

        // random traffic
        for (int k = 0; k < 500; k++) begin
            rnd_rdy = model_ready();
            mc_lat  = $urandom_range(0, 5);
            for (int i = 0; i < NREQ; i++) begin
                if (rnd_rdy[i] && $urandom_range(0, 3) == 0)
                    post(i, 1'($urandom), 10'($urandom), 30'($urandom));
            end
            eval();
        end
        run_idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
